// File: rtl/io_seq_pkg.sv
// Shared definitions for the IO pattern sequencer: register offsets,
// CTRL/STATUS bit positions and the sequencer state encoding.
package io_seq_pkg;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_RANGE  = 4'h4;
  localparam logic [3:0] REG_HOLD   = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'hC;

  // CTRL bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_LOOP    = 1;
  localparam int CTRL_TAIL_EN = 2;
  localparam int CTRL_ABORT   = 3;

  // STATUS bit positions
  localparam int STATUS_BUSY   = 0;
  localparam int STATUS_DONE   = 1;
  localparam int STATUS_IO_LSB = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    TAIL_HI = 3'd2,
    TAIL_LO = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

  // A sequence is in progress while stepping values or driving the tail
  function automatic logic is_busy(input seq_state_e s);
    return (s == RUN) || (s == TAIL_HI) || (s == TAIL_LO);
  endfunction

endpackage

// File: rtl/io_seq_wb_regs.sv
// Wishbone slave for the IO pattern sequencer: address decode, single-cycle
// registered ack, byte-selectable register storage, readback mux and the
// start/abort command pulses.
module io_seq_wb_regs
  import io_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          HOLD_W    = 16,
  parameter int          IO_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              busy_i,
  input  logic              done_i,
  input  logic [IO_W-1:0]   io_out_i,
  output logic              start_o,
  output logic              abort_o,
  output logic              loop_o,
  output logic              tail_en_o,
  output logic [IO_W-1:0]   start_val_o,
  output logic [IO_W-1:0]   end_val_o,
  output logic [HOLD_W-1:0] hold_o
);

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              loop_q, loop_d;
  logic              tail_en_q, tail_en_d;
  logic [2*IO_W-1:0] range_q, range_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic        hit;
  logic        accept;
  logic        wr_accept;
  logic        ctrl_wr;
  logic [3:0]  offset;
  logic [31:0] rdata;
  logic        unused_bits;

  // An access is taken once: the cycle ack is high blocks a second accept
  // on the same strobe.
  assign hit       = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept    = hit && !ack_q;
  assign wr_accept = accept && wbs_we_i;
  assign offset    = {wbs_adr_i[3:2], 2'b00};
  assign ctrl_wr   = wr_accept && (offset == REG_CTRL) && wbs_sel_i[0];

  // Command bits act for exactly the accepting cycle and are never stored
  assign start_o = ctrl_wr && wbs_dat_i[CTRL_START];
  assign abort_o = ctrl_wr && wbs_dat_i[CTRL_ABORT];

  // Register write path with byte-lane masking
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    loop_d    = loop_q;
    tail_en_d = tail_en_q;
    range_d   = range_q;
    hold_d    = hold_q;
    if (wr_accept) begin
      case (offset)
        REG_CTRL: begin
          if (wbs_sel_i[0]) begin
            loop_d    = wbs_dat_i[CTRL_LOOP];
            tail_en_d = wbs_dat_i[CTRL_TAIL_EN];
          end
        end
        REG_RANGE: begin
          for (int i = 0; i < 2*IO_W; i++) begin
            if (wbs_sel_i[i/8]) range_d[i] = wbs_dat_i[i];
          end
        end
        REG_HOLD: begin
          for (int i = 0; i < HOLD_W; i++) begin
            if (wbs_sel_i[i/8]) hold_d[i] = wbs_dat_i[i];
          end
        end
        default: ;  // STATUS is read-only; writes are acked and dropped
      endcase
    end
  end

  // Readback mux; start and abort always read as zero
  always_comb begin
    rdata = '0;
    case (offset)
      REG_CTRL: begin
        rdata[CTRL_LOOP]    = loop_q;
        rdata[CTRL_TAIL_EN] = tail_en_q;
      end
      REG_RANGE: rdata[2*IO_W-1:0] = range_q;
      REG_HOLD:  rdata[HOLD_W-1:0] = hold_q;
      REG_STATUS: begin
        rdata[STATUS_BUSY]            = busy_i;
        rdata[STATUS_DONE]            = done_i;
        rdata[STATUS_IO_LSB +: IO_W]  = io_out_i;
      end
      default: ;
    endcase
  end

  // Ack and read data are registered so they appear one cycle after the hit
  always_comb begin
    ack_d = accept;
    dat_d = (accept && !wbs_we_i) ? rdata : '0;
  end

  // Bus response and configuration registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      loop_q    <= 1'b0;
      tail_en_q <= 1'b0;
      range_q   <= '0;
      hold_q    <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      loop_q    <= loop_d;
      tail_en_q <= tail_en_d;
      range_q   <= range_d;
      hold_q    <= hold_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign loop_o      = loop_q;
  assign tail_en_o   = tail_en_q;
  assign start_val_o = range_q[IO_W-1:0];
  assign end_val_o   = range_q[2*IO_W-1:IO_W];
  assign hold_o      = hold_q;

  // Address byte offset and upper data/select lanes carry no register bits
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

endmodule

// File: rtl/io_pattern_sequencer.sv
// IO pattern sequencer: steps io_out through a programmable count range,
// optionally followed by an FF/00 tail, each value held a programmable
// number of cycles. Configured and started over Wishbone.
module io_pattern_sequencer
  import io_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          HOLD_W    = 16,
  parameter int          IO_W      = 8
) (
  input  logic            wb_clk_i,
  input  logic            resetb,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb,
  output logic            seq_done
);

  seq_state_e        state_q, state_d;
  logic [IO_W-1:0]   out_q, out_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic              start;
  logic              abort;
  logic              loop_en;
  logic              tail_en;
  logic [IO_W-1:0]   start_val;
  logic [IO_W-1:0]   end_val;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_eff;
  logic              step_end;
  logic              end_action;
  logic              busy;

  io_seq_wb_regs #(
    .BASE_ADDR (BASE_ADDR),
    .HOLD_W    (HOLD_W),
    .IO_W      (IO_W)
  ) u_regs (
    .clk_i       (wb_clk_i),
    .rst_ni      (resetb),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .busy_i      (busy),
    .done_i      (seq_done),
    .io_out_i    (io_out),
    .start_o     (start),
    .abort_o     (abort),
    .loop_o      (loop_en),
    .tail_en_o   (tail_en),
    .start_val_o (start_val),
    .end_val_o   (end_val),
    .hold_o      (hold)
  );

  // A hold of zero still shows each value for one cycle. The counter is
  // reloaded from the live register at every step boundary, so HOLD/RANGE
  // writes during a sequence apply from the next step.
  assign hold_eff = (hold == '0) ? HOLD_W'(1) : hold;
  assign step_end = (cnt_q == HOLD_W'(1));

  // Next-state, next-value and hold counter
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    end_action = 1'b0;
    if (abort) begin
      state_d = IDLE;
      out_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            out_d   = start_val;
            cnt_d   = hold_eff;
          end
        end
        RUN: begin
          if (!step_end) begin
            cnt_d = cnt_q - 1'b1;
          end else if (out_q != end_val) begin
            out_d = out_q + 1'b1;  // wraps FF -> 00
            cnt_d = hold_eff;
          end else if (tail_en) begin
            state_d = TAIL_HI;
            out_d   = '1;
            cnt_d   = hold_eff;
          end else begin
            end_action = 1'b1;
          end
        end
        TAIL_HI: begin
          if (!step_end) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = TAIL_LO;
            out_d   = '0;
            cnt_d   = hold_eff;
          end
        end
        TAIL_LO: begin
          if (!step_end) cnt_d = cnt_q - 1'b1;
          else           end_action = 1'b1;
        end
        default: begin
          state_d = IDLE;
          out_d   = '0;
          cnt_d   = '0;
        end
      endcase

      // Finishing the pattern either restarts it or parks with the last value
      if (end_action) begin
        if (loop_en) begin
          state_d = RUN;
          out_d   = start_val;
          cnt_d   = hold_eff;
        end else begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
    end
  end

  // Sequencer state, pad value and hold counter
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pads are released only in IDLE; DONE keeps driving the last value
  assign busy     = is_busy(state_q);
  assign seq_done = (state_q == DONE);
  assign io_out   = out_q;
  assign io_oeb   = (state_q == IDLE) ? '1 : '0;

endmodule

// File: tb/tb_io_pattern_sequencer.sv
// Self-checking bench for io_pattern_sequencer. A queue-based model expands
// each started pattern into the per-cycle io_out values; a negedge process
// compares the pads against it every cycle, and directed literal checks pin
// latencies, register readback and the model itself.
`timescale 1ns/1ps
module tb_io_pattern_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        resetb;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [7:0]  io_out, io_oeb;
  logic        seq_done;

  always #5 clk = ~clk;

  io_pattern_sequencer #(
    .BASE_ADDR (BASE),
    .HOLD_W    (16),
    .IO_W      (8)
  ) dut (
    .wb_clk_i  (clk),
    .resetb    (resetb),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .seq_done  (seq_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_q[$];
  bit          m_busy, m_done, m_loop, m_tail, chk_en;
  logic [7:0]  m_last, m_start, m_end, m_exp;
  logic [15:0] m_hold;

  // Expand one pass of the pattern into per-cycle pad values
  task automatic m_build();
    int h;
    logic [7:0] v;
    h = (m_hold == 16'd0) ? 1 : int'(m_hold);
    v = m_start;
    m_q.delete();
    for (int n = 0; n < 256; n++) begin
      for (int k = 0; k < h; k++) m_q.push_back(v);
      if (v == m_end) break;
      v = v + 8'd1;
    end
    if (m_tail) begin
      for (int k = 0; k < h; k++) m_q.push_back(8'hFF);
      for (int k = 0; k < h; k++) m_q.push_back(8'h00);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_loop = 0; m_tail = 0;
    m_last = 8'h00; m_start = 8'h00; m_end = 8'h00; m_hold = 16'h0;
    m_q.delete();
  endtask

  // Per-cycle pad comparison against the model
  always @(negedge clk) begin
    if (chk_en && resetb) begin
      if (m_busy && m_q.size() == 0) begin
        if (m_loop) m_build();
        else begin m_busy = 0; m_done = 1; end
      end
      if (m_busy) begin
        m_exp  = m_q.pop_front();
        m_last = m_exp;
        check("cyc_io_out", {24'h0, io_out}, {24'h0, m_exp});
        check("cyc_io_oeb", {24'h0, io_oeb}, 32'h00);
        check("cyc_seq_done", {31'h0, seq_done}, 32'h0);
      end else if (m_done) begin
        check("cyc_io_out_done", {24'h0, io_out}, {24'h0, m_last});
        check("cyc_io_oeb", {24'h0, io_oeb}, 32'h00);
        check("cyc_seq_done", {31'h0, seq_done}, 32'h1);
      end else begin
        check("cyc_io_out_idle", {24'h0, io_out}, 32'h00);
        check("cyc_io_oeb_idle", {24'h0, io_oeb}, 32'hFF);
        check("cyc_seq_done", {31'h0, seq_done}, 32'h0);
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_xfer(input logic [31:0] a, input logic we, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = sel;
    lat = -1;
    rd  = '0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin lat = n; rd = wbs_dat_o; break; end
    end
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] rd;
    int lat;
    wb_xfer(BASE + {28'h0, off}, 1'b1, d, sel, rd, lat);
    check("wr_ack_latency", lat, 1);
    case (off)
      4'h0: if (sel[0]) begin
        m_loop = d[1];
        m_tail = d[2];
        if (d[3]) begin
          m_busy = 0; m_done = 0; m_q.delete();
        end else if (d[0] && !m_busy) begin
          m_build(); m_busy = 1; m_done = 0;
        end
      end
      4'h4: begin
        if (sel[0]) m_start = d[7:0];
        if (sel[1]) m_end   = d[15:8];
      end
      4'h8: begin
        if (sel[0]) m_hold[7:0]  = d[7:0];
        if (sel[1]) m_hold[15:8] = d[15:8];
      end
      default: ;
    endcase
  endtask

  task automatic wb_read(input logic [3:0] off, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    int lat;
    wb_xfer(BASE + {28'h0, off}, 1'b0, 32'h0, 4'hF, rd, lat);
    check("rd_ack_latency", lat, 1);
    check(name, rd, exp);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!seq_done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    resetb = 0;
    m_reset();
    #1;
    check("rst_io_out", {24'h0, io_out}, 32'h00);
    check("rst_io_oeb", {24'h0, io_oeb}, 32'hFF);
    check("rst_seq_done", {31'h0, seq_done}, 32'h0);
    repeat (2) @(posedge clk);
    #2 resetb = 1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] rd;
    int lat, n;
    resetb = 0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    chk_en = 0;
    m_reset();
    #3;
    check("reset_io_out", {24'h0, io_out}, 32'h00);
    check("reset_io_oeb", {24'h0, io_oeb}, 32'hFF);
    check("reset_seq_done", {31'h0, seq_done}, 32'h0);
    check("reset_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("reset_dat", wbs_dat_o, 32'h0);
    repeat (3) @(posedge clk);
    #2 resetb = 1;
    chk_en = 1;

    wb_read(4'h0, 32'h0, "reset_ctrl");
    wb_read(4'h4, 32'h0, "reset_range");
    wb_read(4'h8, 32'h0, "reset_hold");
    wb_read(4'hC, 32'h0, "reset_status");

    // Byte selects and read-only STATUS
    wb_write(4'h4, 32'h0000_AABB, 4'b0010);
    wb_read(4'h4, 32'h0000_AA00, "range_bytesel");
    wb_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    wb_read(4'hC, 32'h0, "status_ro");
    wb_write(4'h8, 32'h1234_5678, 4'hF);
    wb_read(4'h8, 32'h0000_5678, "hold_width");

    // Count 01..0A hold 4, then FF/00 tail
    wb_write(4'h4, 32'h0000_0A01, 4'hF);
    wb_write(4'h8, 32'd4, 4'hF);
    wb_write(4'h0, 32'h5, 4'hF);
    check("t1_first", {24'h0, io_out}, 32'h01);
    wait_done(n);
    check("t1_done_latency", n, 48);
    check("t1_last", {24'h0, io_out}, 32'h00);
    wb_read(4'hC, 32'h0000_0002, "t1_status");

    // Wrap FE..01 hold 1
    wb_write(4'h8, 32'd1, 4'hF);
    wb_write(4'h4, 32'h0000_01FE, 4'hF);
    wb_write(4'h0, 32'h1, 4'hF);
    check("t2_first", {24'h0, io_out}, 32'hFE);
    wait_done(n);
    check("t2_done_latency", n, 4);
    check("t2_last", {24'h0, io_out}, 32'h01);

    // HOLD=0 acts as 1, single step
    wb_write(4'h8, 32'd0, 4'hF);
    wb_write(4'h4, 32'h0000_0505, 4'hF);
    wb_write(4'h0, 32'h1, 4'hF);
    wait_done(n);
    check("t3_done_latency", n, 1);
    wb_read(4'hC, 32'h0000_0502, "t3_status");

    // Loop 02,03 hold 2, then abort
    wb_write(4'h8, 32'd2, 4'hF);
    wb_write(4'h4, 32'h0000_0302, 4'hF);
    wb_write(4'h0, 32'h3, 4'hF);
    check("t4_first", {24'h0, io_out}, 32'h02);
    repeat (20) @(posedge clk);
    wb_write(4'h0, 32'h8, 4'hF);
    check("t4_abort_oeb", {24'h0, io_oeb}, 32'hFF);
    check("t4_abort_out", {24'h0, io_out}, 32'h00);
    wb_read(4'hC, 32'h0, "t4_status");

    // Start while busy, miss address, then reset mid-run
    wb_write(4'h4, 32'h0000_2010, 4'hF);
    wb_write(4'h0, 32'h1, 4'hF);
    repeat (5) @(posedge clk);
    wb_write(4'h0, 32'h1, 4'hF);
    wb_xfer(BASE + 32'h10, 1'b0, 32'h0, 4'hF, rd, lat);
    check("t5_miss_no_ack", lat, -1);
    wb_xfer(BASE + 32'hC, 1'b0, 32'h0, 4'hF, rd, lat);
    check("t5_status_lat", lat, 1);
    check("t5_status_busy", rd & 32'h3, 32'h1);
    repeat (3) @(posedge clk);
    pulse_reset();
    wb_read(4'hC, 32'h0, "t6_status");
    wb_read(4'h4, 32'h0, "t6_range");
    wb_write(4'h8, 32'd1, 4'hF);
    wb_write(4'h4, 32'h0000_0403, 4'hF);
    wb_write(4'h0, 32'h1, 4'hF);
    check("t6_first", {24'h0, io_out}, 32'h03);
    wait_done(n);
    check("t6_done_latency", n, 2);
    check("t6_last", {24'h0, io_out}, 32'h04);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
